// File: rtl/dmem_pkg.sv
// Shared types and constants for the synchronous data memory: access size codes,
// fault bit positions, controller state encoding and the response sideband record.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int FAULT_ALIGN = 0;
    localparam int FAULT_RANGE = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Everything the response needs besides the raw array word.
    typedef struct packed {
        logic       we;
        logic [1:0] fault;
        logic [1:0] lane;
        logic [1:0] size;
        logic       uns;
    } rsp_sb_t;

    // Size 3 is never legal; halves need an even lane, words lane 0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic r;
        case (size)
            SIZE_B:  r = 1'b0;
            SIZE_H:  r = lane[0];
            SIZE_W:  r = (lane != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables plus lane replication, and
// load extraction with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_lane,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_wdata,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_lane,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [3:0]  w_be_base;
    logic [31:0] w_ld_shift;

    // Store side: replicate data into every lane, enables select the real ones.
    always_comb begin
        w_be_base  = 4'b0000;
        o_st_wdata = 32'h0000_0000;
        case (i_st_size)
            SIZE_B: begin
                w_be_base  = 4'b0001;
                o_st_wdata = {4{i_st_wdata[7:0]}};
            end
            SIZE_H: begin
                w_be_base  = 4'b0011;
                o_st_wdata = {2{i_st_wdata[15:0]}};
            end
            SIZE_W: begin
                w_be_base  = 4'b1111;
                o_st_wdata = i_st_wdata;
            end
            default: begin
                w_be_base  = 4'b0000;
                o_st_wdata = 32'h0000_0000;
            end
        endcase
        o_st_be = w_be_base << i_st_lane;
    end

    // Load side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        w_ld_shift = i_ld_word >> {i_ld_lane, 3'b000};
        o_ld_data  = 32'h0000_0000;
        case (i_ld_size)
            SIZE_B: begin
                if (i_ld_unsigned) begin
                    o_ld_data = {24'h00_0000, w_ld_shift[7:0]};
                end else begin
                    o_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
                end
            end
            SIZE_H: begin
                if (i_ld_unsigned) begin
                    o_ld_data = {16'h0000, w_ld_shift[15:0]};
                end else begin
                    o_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
                end
            end
            SIZE_W: begin
                o_ld_data = w_ld_shift;
            end
            default: begin
                o_ld_data = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_sync.sv
// Synchronous word-organised data memory behind a valid/ready request port, with
// fault checking, a READ_LAT-deep response pipeline and an optional clear sweep.
module dmem_sync
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0100_0000,
    parameter int          DEPTH_WORDS    = 262144,
    parameter int          READ_LAT       = 1,
    parameter int          CLEAR_ON_RESET = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic [1:0]  o_rsp_fault,
    output logic        o_rsp_we
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [AW-1:0]   w_clr_cnt_nxt;

    logic            w_accept;
    logic [31:0]     w_offset;
    logic [1:0]      w_fault;
    logic [AW-1:0]   w_word_idx;
    logic            w_store;
    logic            w_clear_wr;
    logic [3:0]      w_st_be;
    logic [31:0]     w_st_wdata;
    logic [31:0]     w_ld_data;
    rsp_sb_t         w_sb_in;
    rsp_sb_t         w_sb_out;

    logic [31:0]     r_mem       [DEPTH_WORDS];
    logic            r_pipe_vld  [READ_LAT];
    rsp_sb_t         r_pipe_sb   [READ_LAT];
    logic [31:0]     r_pipe_word [READ_LAT];

    assign o_req_ready = (r_state == ST_RUN);
    assign w_accept    = i_req_valid && o_req_ready && !i_reset;
    assign w_offset    = i_req_addr - BASE_ADDR;
    assign w_word_idx  = w_offset[AW+1:2];

    // Request decode: both fault kinds are evaluated independently.
    always_comb begin
        w_fault              = 2'b00;
        w_fault[FAULT_ALIGN] = is_misaligned(i_req_size, w_offset[1:0]);
        w_fault[FAULT_RANGE] = ({1'b0, w_offset} >= RANGE_BYTES);
        w_store              = w_accept && i_req_we && (w_fault == 2'b00);
        w_clear_wr           = (r_state == ST_CLEAR) && !i_reset;
        w_sb_in              = '{we: i_req_we, fault: w_fault, lane: w_offset[1:0],
                                 size: i_req_size, uns: i_req_unsigned};
    end

    // Clear-sweep controller: next state and counter.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_cnt == AW'(DEPTH_WORDS - 1)) begin
                    w_state_nxt   = ST_RUN;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                end
            end
            ST_RUN: begin
                w_state_nxt   = ST_RUN;
                w_clr_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt   = ST_RUN;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // Controller state register; reset restarts the sweep from word 0.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    dmem_lane_align u_lane_align (
        .i_st_size     (i_req_size),
        .i_st_lane     (w_offset[1:0]),
        .i_st_wdata    (i_req_wdata),
        .o_st_be       (w_st_be),
        .o_st_wdata    (w_st_wdata),
        .i_ld_size     (w_sb_out.size),
        .i_ld_lane     (w_sb_out.lane),
        .i_ld_unsigned (w_sb_out.uns),
        .i_ld_word     (r_pipe_word[READ_LAT-1]),
        .o_ld_data     (w_ld_data)
    );

    // Array port: sweep or byte-enabled store, plus the synchronous read into stage 0.
    always_ff @(posedge i_clock) begin
        if (w_clear_wr) begin
            r_mem[r_clr_cnt] <= 32'h0000_0000;
        end else if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_st_be[b]) begin
                    r_mem[w_word_idx][8*b +: 8] <= w_st_wdata[8*b +: 8];
                end
            end
        end
        r_pipe_word[0] <= r_mem[w_word_idx];
    end

    // Read-data delay stages beyond the array register carry no control state.
    always_ff @(posedge i_clock) begin
        for (int i = 1; i < READ_LAT; i++) begin
            r_pipe_word[i] <= r_pipe_word[i-1];
        end
    end

    // Valid and sideband pipeline; reset drops everything in flight.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_sb[i]  <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_accept;
            r_pipe_sb[0]  <= w_accept ? w_sb_in : '0;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_sb[i]  <= r_pipe_sb[i-1];
            end
        end
    end

    assign w_sb_out    = r_pipe_sb[READ_LAT-1];
    assign o_rsp_valid = r_pipe_vld[READ_LAT-1];
    assign o_rsp_fault = w_sb_out.fault;
    assign o_rsp_we    = w_sb_out.we;

    // Stores and faulting loads return zero data.
    always_comb begin
        if (o_rsp_valid && !w_sb_out.we && (w_sb_out.fault == 2'b00)) begin
            o_rsp_rdata = w_ld_data;
        end else begin
            o_rsp_rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_dmem_sync.sv
// Scoreboard bench for dmem_sync: a byte-level reference model predicts each response,
// which is queued with its due cycle and compared when the DUT should produce it.
module tb_dmem_sync;
    import dmem_pkg::*;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 16;
    localparam int          LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, ready, we, uns;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        rsp_valid, rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_fault;

    always #5 clk = ~clk;

    dmem_sync #(
        .BASE_ADDR      (BASE),
        .DEPTH_WORDS    (DEPTH),
        .READ_LAT       (LAT),
        .CLEAR_ON_RESET (1)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_req_valid    (valid),
        .o_req_ready    (ready),
        .i_req_we       (we),
        .i_req_addr     (addr),
        .i_req_size     (size),
        .i_req_unsigned (uns),
        .i_req_wdata    (wdata),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_fault    (rsp_fault),
        .o_rsp_we       (rsp_we)
    );

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic [1:0]  fault;
        logic        we;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl [DEPTH*4];
    int         cyc    = 0;
    int         n_cmp  = 0;
    int         n_err  = 0;
    bit         mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'h00;
    endtask

    // Drive one request for one cycle; predict its response from the byte model.
    task automatic req(input logic r_we, input logic [31:0] r_addr, input logic [1:0] r_size,
                       input logic r_uns, input logic [31:0] r_wdata);
        exp_t        e;
        logic [31:0] off, val, msk;
        int          nb;
        @(posedge clk); #2;
        valid = 1'b1; we = r_we; addr = r_addr; size = r_size; uns = r_uns; wdata = r_wdata;
        off        = r_addr - BASE;
        e.fault[1] = (off >= 32'(DEPTH*4));
        e.fault[0] = (r_size == 2'd3) || (r_size == 2'd1 && off[0]) ||
                     (r_size == 2'd2 && off[1:0] != 2'b00);
        nb  = (r_size == 2'd0) ? 1 : (r_size == 2'd1) ? 2 : 4;
        val = 32'h0;
        if (e.fault == 2'b00) begin
            if (r_we) begin
                for (int i = 0; i < nb; i++) mdl[int'(off[5:0]) + i] = r_wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) val = val | (32'(mdl[int'(off[5:0]) + i]) << (8*i));
                if (nb < 4) begin
                    msk = (32'd1 << (8*nb)) - 32'd1;
                    if (!r_uns && val[8*nb-1]) val = val | ~msk;
                end
            end
        end
        e.rdata = val;
        e.we    = r_we;
        e.due   = cyc + LAT;
        check_val("req_ready", ready, 32'd1);
        if (ready) sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #2;
        valid = 1'b0;
    endtask

    // Count cycles with req_ready low after reset is released.
    task automatic wait_clear();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            if (ready !== 1'b1) n++;
        end
        check_val("clear_len", n, DEPTH);
    endtask

    // Response monitor: the head of the scoreboard is due exactly at its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check_val("rsp_valid", rsp_valid, 32'd1);
                check_val("rsp_rdata", rsp_rdata, e.rdata);
                check_val("rsp_fault", rsp_fault, e.fault);
                check_val("rsp_we", rsp_we, e.we);
            end else begin
                check_val("idle_valid", rsp_valid, 32'd0);
            end
        end
    end

    initial begin
        rst = 1'b1; valid = 1'b0; we = 1'b0; addr = 32'h0; size = 2'd0; uns = 1'b0; wdata = 32'h0;
        model_clear();
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_ready", ready, 32'd0);
        check_val("rst_rsp_valid", rsp_valid, 32'd0);
        check_val("rst_rdata", rsp_rdata, 32'd0);
        check_val("rst_fault", rsp_fault, 32'd0);
        check_val("rst_we", rsp_we, 32'd0);
        mon_en = 1'b1;
        rst    = 1'b0;
        wait_clear();

        req(1'b0, BASE + 32'd4, SIZE_W, 1'b0, 32'h0);
        req(1'b1, BASE, SIZE_W, 1'b0, 32'h8765_4321);
        req(1'b0, BASE + 32'd1, SIZE_B, 1'b1, 32'h0);
        req(1'b0, BASE + 32'd2, SIZE_H, 1'b0, 32'h0);
        req(1'b1, BASE + 32'd4, SIZE_W, 1'b0, 32'h1122_3344);
        req(1'b1, BASE + 32'd7, SIZE_B, 1'b0, 32'h0000_00AB);
        req(1'b0, BASE + 32'd4, SIZE_W, 1'b0, 32'h0);
        req(1'b1, BASE + 32'd1, SIZE_H, 1'b0, 32'h0000_BEEF);
        req(1'b0, BASE + 32'd2, SIZE_W, 1'b0, 32'h0);
        req(1'b0, BASE, SIZE_W, 1'b0, 32'h0);
        req(1'b0, 32'h00FF_FFFC, SIZE_W, 1'b0, 32'h0);
        req(1'b0, BASE + 32'(DEPTH*4), SIZE_W, 1'b0, 32'h0);
        req(1'b0, BASE + 32'(DEPTH*4), 2'd3, 1'b0, 32'h0);
        req(1'b1, BASE + 32'(DEPTH*4) + 32'd1, SIZE_B, 1'b0, 32'h0000_0055);
        req(1'b1, BASE + 32'd10, SIZE_H, 1'b0, 32'h0000_C0DE);
        req(1'b0, BASE + 32'd10, SIZE_H, 1'b0, 32'h0);
        req(1'b0, BASE + 32'd11, SIZE_B, 1'b0, 32'h0);
        req(1'b0, BASE + 32'd10, SIZE_H, 1'b1, 32'h0);
        idle();

        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            a = BASE + 32'($urandom_range(0, 71));
            if ($urandom_range(0, 7) == 0) a = BASE - 32'($urandom_range(1, 8));
            req(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom);
        end
        idle();
        repeat (LAT + 1) @(posedge clk);

        // Four back-to-back loads, reset lands with the last two in flight.
        req(1'b1, BASE + 32'd20, SIZE_W, 1'b0, 32'hCAFE_F00D);
        req(1'b0, BASE + 32'd20, SIZE_W, 1'b0, 32'h0);
        req(1'b0, BASE + 32'd21, SIZE_B, 1'b1, 32'h0);
        req(1'b0, BASE + 32'd22, SIZE_H, 1'b0, 32'h0);
        req(1'b0, BASE + 32'd20, SIZE_W, 1'b1, 32'h0);
        @(posedge clk); #2;
        valid = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #2;
        sb.delete();
        rst = 1'b0;
        model_clear();
        wait_clear();
        req(1'b0, BASE + 32'd20, SIZE_W, 1'b0, 32'h0);
        idle();
        repeat (LAT + 2) @(posedge clk);
        check_val("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
